// File: rtl/therm_decoder_pkg.sv
// Shared types and helpers for the thermometer-code decoder.
// Optional error counter is enabled with THERM_ERR_CNT_EN.
package therm_pkg;

    localparam int ERR_CNT_W = 16;
    localparam int RES_CNT_W = 16;

    typedef struct packed {
        logic [RES_CNT_W-1:0] count;
        logic                 dir;
        logic                 err;
    } therm_res_t;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/therm_decoder_if.sv
// Word-in / result-out handshake bundle for therm_decoder.
// master = producer/consumer side, slave = decoder side.
interface therm_decoder_if
    import therm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] codeIn;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_WIDTH-1:0]  out_count;
    logic                  out_dir;
    logic                  out_err;

    modport master (
        output in_valid, codeIn, out_ready,
        input  in_ready, out_valid, out_count, out_dir, out_err
    );

    modport slave (
        input  in_valid, codeIn, out_ready,
        output in_ready, out_valid, out_count, out_dir, out_err
    );
endinterface

// File: rtl/therm_decoder_classify.sv
// Combinational thermometer classifier: exactly one 0/1 boundary is valid.
// Invalid words report count=0, dir=0.
module therm_classify
    import therm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] code_i,
    output logic                  is_therm_o,
    output logic                  dir_o,
    output logic [CNT_WIDTH-1:0]  count_o
);
    logic [DATA_WIDTH-2:0] edge_w;
    logic [DATA_WIDTH-2:0] edge_m1;
    logic [CNT_WIDTH-1:0]  pop;

    // One set bit in edge_w means a single boundary between the 0 and 1 runs.
    assign edge_w  = code_i[DATA_WIDTH-1:1] ^ code_i[DATA_WIDTH-2:0];
    assign edge_m1 = edge_w - (DATA_WIDTH-1)'(1);

    assign is_therm_o = (|edge_w) & ~(|(edge_w & edge_m1));

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop = pop + CNT_WIDTH'(code_i[i]);
        end
    end

    assign dir_o   = is_therm_o & code_i[DATA_WIDTH-1];
    assign count_o = is_therm_o ? pop : '0;

endmodule

// File: rtl/therm_decoder.sv
// Two-stage valid/ready thermometer decoder (classify, then result).
// THERM_ERR_CNT_EN adds err_clr/err_cnt, a saturating invalid-word count.
module therm_decoder
    import therm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    therm_decoder_if.slave       bus
`ifdef THERM_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
    logic                 cls_therm;
    logic                 cls_dir;
    logic [CNT_WIDTH-1:0] cls_cnt;

    logic                 s1_v_q, s1_v_d;
    logic                 s1_therm_q, s1_therm_d;
    logic                 s1_dir_q, s1_dir_d;
    logic [CNT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;

    logic                 s2_v_q, s2_v_d;
    therm_res_t           s2_q, s2_d;

    logic                 in_fire;
    logic                 s1_adv;
    logic                 out_fire;
    logic                 unused_cnt_hi;

    therm_classify #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_classify (
        .code_i     (bus.codeIn),
        .is_therm_o (cls_therm),
        .dir_o      (cls_dir),
        .count_o    (cls_cnt)
    );

    assign out_fire = s2_v_q & bus.out_ready;
    assign s1_adv   = s1_v_q & (~s2_v_q | bus.out_ready);
    assign in_fire  = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = ~s1_v_q | s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.out_count = s2_q.count[CNT_WIDTH-1:0];
    assign bus.out_dir   = s2_q.dir;
    assign bus.out_err   = s2_q.err;

    // Upper result bits are always zero for narrow configurations.
    assign unused_cnt_hi = ^s2_q.count;

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_therm_d = s1_therm_q;
        s1_dir_d   = s1_dir_q;
        s1_cnt_d   = s1_cnt_q;
        if (in_fire) begin
            s1_v_d     = 1'b1;
            s1_therm_d = cls_therm;
            s1_dir_d   = cls_dir;
            s1_cnt_d   = cls_cnt;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d = s2_v_q;
        s2_d   = s2_q;
        if (s1_adv) begin
            s2_v_d     = 1'b1;
            s2_d.count = RES_CNT_W'(s1_cnt_q);
            s2_d.dir   = s1_dir_q;
            s2_d.err   = ~s1_therm_q;
        end else if (out_fire) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q     <= 1'b0;
            s1_therm_q <= 1'b0;
            s1_dir_q   <= 1'b0;
            s1_cnt_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_therm_q <= s1_therm_d;
            s1_dir_q   <= s1_dir_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_v_q     <= s2_v_d;
            s2_q       <= s2_d;
        end
    end

`ifdef THERM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (out_fire && s2_q.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/therm_decoder.md
THERM_DECODER -- requirements
Module: therm_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the thermometer word width in bits (minimum 2).
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(DATA_WIDTH+1), giving the output count width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and codeIn (input, DATA_WIDTH): the upstream thermometer word handshake.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_count (output, CNT_WIDTH), out_dir (output, 1) and out_err (output, 1): the decoded result handshake.
REQ-007 SHALL have ports err_clr (input, 1) and err_cnt (output, 16): a saturating count of invalid words; these ports exist only under THERM_ERR_CNT_EN.

Function
REQ-008 SHALL transfer a word on any cycle where in_valid and in_ready are both 1, and a result on any cycle where out_valid and out_ready are both 1.
REQ-009 SHALL classify a word as valid thermometer code only if it is m zeros (MSB side) followed by ones, or m ones (MSB side) followed by zeros, with 0 < m < DATA_WIDTH.
REQ-010 SHALL treat all-zeros and all-ones words as invalid.
REQ-011 For a valid word, SHALL set out_count to the number of 1 bits and out_err to 0.
REQ-012 For a valid word, SHALL set out_dir to 0 when the ones occupy the LSB side and to 1 when they occupy the MSB side.
REQ-013 For an invalid word, SHALL drive out_err=1, out_count=0 and out_dir=0.
REQ-014 SHALL be a two-stage pipeline: stage S1 registers the word and its validity/direction flags; stage S2 registers count, dir and err.
REQ-015 SHALL assert out_valid exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-016 SHALL sustain a throughput of one word per cycle while out_ready is held at 1.
REQ-017 Each stage SHALL advance when its successor is empty or is being emptied in the same cycle, giving in_ready = ~S1_valid | S1_advance.
REQ-018 SHALL hold out_valid, out_count, out_dir and out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL neither drop nor duplicate words under any pattern of backpressure.
REQ-020 SHALL contain no combinational path from in_valid to out_valid.
REQ-021 SHALL allow in_ready to depend combinationally on out_ready.

Reset
REQ-022 Reset SHALL clear both stage valid bits, drive out_valid=0, out_count=0, out_dir=0, out_err=0 and clear err_cnt to 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight words, with no output transfer in the cycle after reset.
REQ-024 in_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-025 Macro THERM_ERR_CNT_EN defined: err_cnt SHALL increment by 1 on each output transfer with out_err=1 and saturate at 16'hFFFF.
REQ-026 With THERM_ERR_CNT_EN defined, err_clr=1 SHALL zero err_cnt on the next edge, taking priority over a simultaneous increment.
REQ-027 Macro THERM_ERR_CNT_EN undefined: err_clr, err_cnt and the counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package therm_pkg SHALL hold the result struct typedef (count, dir, err), the ERR_CNT_W=16 constant and the function computing CNT_WIDTH.
REQ-029 Classification SHALL be a combinational sub-module therm_classify (codeIn -> is_therm, dir, count), instantiated once in S1.

Verification (DATA_WIDTH=8)
REQ-030 Send 8'b00001111 with out_ready=1 -> out_valid 2 cycles later with count=4, dir=0, err=0.
REQ-031 Send 8'b11100000, 8'b00000000, 8'b11111111, 8'b01010000 back-to-back -> results (3,1,0), (0,0,1), (0,0,1), (0,0,1) on consecutive cycles.
REQ-032 Hold out_ready=0 for 5 cycles while offering 4 words -> in_ready drops after 2 words are accepted; all words later emerge in order with none lost.
REQ-033 Assert reset while 2 words are in flight -> out_valid=0 and in_ready=1 after reset; no stale result appears.
REQ-034 With THERM_ERR_CNT_EN, send 70000 invalid words -> err_cnt=16'hFFFF; err_clr pulsed during an error transfer -> err_cnt=0.
